// File: rtl/spec_readout_if.sv
// Output stream of the spectrum readout: valid/ready handshake with a last-word marker.
interface spec_readout_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic [DATA_W-1:0] data_out;
    logic              data_valid_out;
    logic              data_ready_in;
    logic              data_last_out;

    modport master (
        output data_out,
        output data_valid_out,
        output data_last_out,
        input  data_ready_in
    );

    modport slave (
        input  data_out,
        input  data_valid_out,
        input  data_last_out,
        output data_ready_in
    );
endinterface

// File: rtl/spec_readout.sv
// Streams accumulated spectra out of the accumulation DPRAM after a pass completes,
// with optional saturating background subtraction and a credit-limited output FIFO.
module spec_readout #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned BIN_BITS   = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4:0]          range_bins,
    input  logic                bg_sub_en,
    output logic [ADDR_W-1:0]   rdaddr_out,
    output logic [BIN_BITS-1:0] bg_rdaddr_out,
    input  logic [DATA_W-1:0]   dpram_dout,
    input  logic [DATA_W-1:0]   bg_dout,
    spec_readout_if.master      dout_if,
    output logic                busy,
    output logic                done
);

    localparam int unsigned BANK_W = ADDR_W - BIN_BITS;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } word_t;

    state_t state_q, state_d;

    logic [4:0]          rb_q;
    logic                bg_en_q;
    logic [4:0]          bin_q;
    logic [BIN_BITS-1:0] idx_q;
    logic [CNT_W-1:0]    outstanding_q;
    logic [RD_LAT:0]     vld_sr_q;
    logic [RD_LAT:0]     last_sr_q;

    word_t               fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [DATA_W-1:0]   data_q;
    logic                valid_q, last_q;

    logic                issue_c, issue_last_c, credit_c, pop_c, wr_c;
    logic [4:0]          issue_bin_c;
    logic [BIN_BITS-1:0] issue_idx_c;
    logic [DATA_W-1:0]   res_c;
    word_t               wdata_c, head_c;
    logic [PTR_W-1:0]    rd_nxt_c;
    logic [CNT_W-1:0]    count_d_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign credit_c = outstanding_q < CNT_W'(FIFO_DEPTH);
    assign pop_c    = valid_q && dout_if.data_ready_in;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (range_bins == 5'd0) ? S_DONE : S_READ;
            S_READ:  if (issue_c && issue_last_c) state_d = S_DRAIN;
            S_DRAIN: if (pop_c && outstanding_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read-issue decisions; the first address goes out on the start cycle itself
    always_comb begin
        issue_c      = 1'b0;
        issue_last_c = 1'b0;
        issue_bin_c  = bin_q;
        issue_idx_c  = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start && range_bins != 5'd0) begin
                    issue_c     = 1'b1;
                    issue_bin_c = 5'd0;
                    issue_idx_c = '0;
                end
            end
            S_READ: begin
                if (credit_c) begin
                    issue_c      = 1'b1;
                    issue_last_c = (bin_q == rb_q - 5'd1) && (&idx_q);
                end
            end
            default: ;
        endcase
    end

    // Address walk, configuration latch, status outputs and in-flight tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_q          <= '0;
            bg_en_q       <= 1'b0;
            bin_q         <= '0;
            idx_q         <= '0;
            rdaddr_out    <= '0;
            bg_rdaddr_out <= '0;
            outstanding_q <= '0;
            vld_sr_q      <= '0;
            last_sr_q     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                rb_q    <= range_bins;
                bg_en_q <= bg_sub_en;
            end
            if (issue_c) begin
                rdaddr_out    <= {BANK_W'(issue_bin_c), issue_idx_c};
                bg_rdaddr_out <= issue_idx_c;
                if (&issue_idx_c) begin
                    idx_q <= '0;
                    bin_q <= issue_bin_c + 5'd1;
                end else begin
                    idx_q <= issue_idx_c + 1'b1;
                    bin_q <= issue_bin_c;
                end
            end
            outstanding_q <= outstanding_q + CNT_W'(issue_c) - CNT_W'(pop_c);
            vld_sr_q      <= {vld_sr_q[RD_LAT-1:0], issue_c};
            last_sr_q     <= {last_sr_q[RD_LAT-1:0], issue_c && issue_last_c};
            busy          <= (state_d == S_READ) || (state_d == S_DRAIN);
            done          <= (state_d == S_DONE);
        end
    end

    // Saturating unsigned background subtraction on the landing read data
    always_comb begin
        res_c = dpram_dout;
        if (bg_en_q) res_c = (dpram_dout >= bg_dout) ? dpram_dout - bg_dout : '0;
        wr_c         = vld_sr_q[RD_LAT];
        wdata_c.data = res_c;
        wdata_c.last = last_sr_q[RD_LAT];
    end

    // Next FIFO head; a write into an empty (or emptying) FIFO bypasses straight to the head
    always_comb begin
        rd_nxt_c  = pop_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d_c = count_q + CNT_W'(wr_c) - CNT_W'(pop_c);
        head_c    = fifo_q[rd_nxt_c];
        if (wr_c && (count_q - CNT_W'(pop_c)) == '0) head_c = wdata_c;
    end

    always_ff @(posedge clk) begin
        if (wr_c) fifo_q[wr_ptr_q] <= wdata_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            if (wr_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
            rd_ptr_q <= rd_nxt_c;
            count_q  <= count_d_c;
            valid_q  <= (count_d_c != '0);
            if (count_d_c != '0) begin
                data_q <= head_c.data;
                last_q <= head_c.last;
            end else begin
                last_q <= 1'b0;
            end
        end
    end

    assign dout_if.data_out       = data_q;
    assign dout_if.data_valid_out = valid_q;
    assign dout_if.data_last_out  = last_q;

endmodule
